// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and board constants for the button pulse conditioner and related key logic.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  // 10 ms debounce window and 250 ms auto-repeat period at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = CLK_FREQ_HZ / 4;

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Key-side signal bundle: raw key in, conditioned pulse/level/count out.
interface button_pulse_conditioner_if;
  logic       btn_raw;
  logic       dec_pulse;
  logic       btn_level;
  logic [7:0] press_cnt;

  modport master (output btn_raw, input dec_pulse, btn_level, press_cnt);
  modport slave  (input btn_raw, output dec_pulse, btn_level, press_cnt);
endinterface

// File: rtl/button_pulse_conditioner_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // NOTE: non-blocking assignments make s1 and q behave as two real flops; blocking would collapse them into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Synchronises and debounces a raw key, emitting one dec_pulse per accepted press.
// Define BUTTON_AUTO_REPEAT_EN to add periodic repeat pulses while the key is held.
module button_pulse_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input logic                       clk,
  input logic                       rst,
  button_pulse_conditioner_if.slave bus
);

  localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_IDLE       = IDLE;
  localparam logic [1:0] S_DB_PRESS   = DB_PRESS;
  localparam logic [1:0] S_HELD       = HELD;
  localparam logic [1:0] S_DB_RELEASE = DB_RELEASE;

  logic             btn_sync;
  logic             p;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic             accept;
  logic             rpt_fire;
  logic             pulse_evt;
  logic             dec_pulse_q;
  logic [7:0]       press_cnt_q;

  // Flops start at the released level so reset never looks like a press.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (RELEASED_RAW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_raw),
    .q   (btn_sync)
  );

  assign p = (btn_sync != RELEASED_RAW);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (p) begin
          state_nxt  = S_DB_PRESS;
          db_cnt_nxt = CNT_W'(1);
        end
      end
      S_DB_PRESS: begin
        if (!p) begin
          state_nxt  = S_IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = S_HELD;
          db_cnt_nxt = '0;
          accept     = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!p) begin
          state_nxt  = S_DB_RELEASE;
          db_cnt_nxt = CNT_W'(1);
        end
      end
      S_DB_RELEASE: begin
        if (p) begin
          state_nxt  = S_HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = S_IDLE;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned   RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;

  assign rpt_fire = (state == S_HELD) && (rpt_cnt == RPT_LAST);

  // Runs in HELD, holds its value through a release bounce, restarts on any entry to HELD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt <= '0;
    end else begin
      case (state)
        S_HELD:       rpt_cnt <= rpt_fire ? '0 : rpt_cnt + RPT_W'(1);
        S_DB_RELEASE: if (p) rpt_cnt <= '0;
        default:      rpt_cnt <= '0;
      endcase
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_CYCLES > 0);
  assign rpt_fire       = 1'b0;
`endif

  assign pulse_evt = accept | rpt_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      db_cnt      <= '0;
      dec_pulse_q <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_cnt_nxt;
      dec_pulse_q <= pulse_evt;
      if (pulse_evt) press_cnt_q <= press_cnt_q + 8'd1;
    end
  end

  assign bus.dec_pulse = dec_pulse_q;
  assign bus.btn_level = (state == S_HELD) || (state == S_DB_RELEASE);
  assign bus.press_cnt = press_cnt_q;

endmodule
